lzss_enc_sched: RTL and testbench

//  Sequencer/arbiter for the LZSS encoder match array of pNumMatch compare units.
//  - Drives the array's shared update/clear strobes and fills the look-ahead window.
//  - Selects the best (offset,length) among all units, or falls back to a literal.
//  - Emits one code per token on a valid/ready interface, skips the matched symbols, and stops on the last code.

---
 rtl/lzss_enc_sched_if.sv | 27 ++
 rtl/lzss_enc_sched.sv | 184 ++++++++++++++++++
 tb/tb_lzss_enc_sched.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lzss_enc_sched_if.sv
// Code output channel of the LZSS encoder sequencer: one token per valid/ready
// handshake, either a literal symbol or an (offset,length) match.
interface lzss_enc_sched_if #(
  parameter int pDataWidth   = 8,
  parameter int pOffsetWidth = 6,
  parameter int pLengthWidth = 3
);
  logic                    o_code_valid;
  logic                    i_code_ready;
  logic                    o_code_flag;
  logic [pOffsetWidth-1:0] o_code_offset;
  logic [pLengthWidth-1:0] o_code_length;
  logic [pDataWidth-1:0]   o_code_literal;
  logic                    o_code_last;

  modport master (
    output o_code_valid, o_code_flag, o_code_offset, o_code_length,
           o_code_literal, o_code_last,
    input  i_code_ready
  );

  modport slave (
    input  o_code_valid, o_code_flag, o_code_offset, o_code_length,
           o_code_literal, o_code_last,
    output i_code_ready
  );
endinterface

// File: rtl/lzss_enc_sched.sv
// Sequencer/arbiter for the LZSS match array: fills the look-ahead window,
// picks the longest match (or a literal), emits one code and skips past it.
module lzss_enc_sched #(
  parameter int pDataWidth     = 8,
  parameter int pCodingSize    = 5,
  parameter int pOffsetWidth   = 6,
  parameter int pLengthWidth   = 3,
  parameter int pNumMatch      = 32,
  parameter int pMinLength     = 2,
  parameter int pResultLatency = 1
) (
  input  logic                              clk,
  input  logic                              rst_x,
  input  logic                              i_start,
  input  logic                              i_abort,
  input  logic                              i_src_valid,
  output logic                              o_update,
  output logic                              o_clear,
  input  logic [pNumMatch*pOffsetWidth-1:0] i_match_offset,
  input  logic [pNumMatch*pLengthWidth-1:0] i_match_length,
  input  logic [pNumMatch-1:0]              i_match_last,
  input  logic [pDataWidth-1:0]             i_lit_data,
  input  logic                              i_lit_last,
  lzss_enc_sched_if.master                  code,
  output logic                              o_busy,
  output logic                              o_done
);

  // The counter must hold both the window size and the longest possible skip.
  localparam int CntMax = (pCodingSize > (1 << pLengthWidth)) ? pCodingSize : (1 << pLengthWidth);
  localparam int CntW   = $clog2(CntMax + 1);
  localparam int WcntW  = (pResultLatency > 0) ? $clog2(pResultLatency + 1) : 1;
  localparam int IdxW   = (pNumMatch > 1) ? $clog2(pNumMatch) : 1;
  localparam int SymW   = pLengthWidth + 1;
  localparam logic [SymW-1:0] MinSym = SymW'(pMinLength);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_WAIT,
    ST_EMIT,
    ST_SKIP,
    ST_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [WcntW-1:0]        wcnt_q, wcnt_d;
  logic [CntW-1:0]         skip_q, skip_d;
  logic                    flag_q, flag_d;
  logic [pOffsetWidth-1:0] offset_q, offset_d;
  logic [pLengthWidth-1:0] length_q, length_d;
  logic [pDataWidth-1:0]   literal_q, literal_d;
  logic                    last_q, last_d;

  logic [pLengthWidth-1:0] best_len;
  logic [IdxW-1:0]         best_idx;
  logic [SymW-1:0]         best_sym;
  logic                    is_match;
  logic                    update;
  logic                    clear;

  // Strict greater-than keeps the lowest unit index on equal lengths.
  always_comb begin
    best_len = '0;
    best_idx = '0;
    for (int unsigned i = 0; i < pNumMatch; i++) begin
      if (i_match_length[i*pLengthWidth +: pLengthWidth] > best_len) begin
        best_len = i_match_length[i*pLengthWidth +: pLengthWidth];
        best_idx = IdxW'(i);
      end
    end
  end

  assign best_sym = {1'b0, best_len} + 1'b1;
  assign is_match = (best_sym >= MinSym);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wcnt_d    = wcnt_q;
    skip_d    = skip_q;
    flag_d    = flag_q;
    offset_d  = offset_q;
    length_d  = length_q;
    literal_d = literal_q;
    last_d    = last_q;
    update    = 1'b0;
    clear     = 1'b0;

    if (i_abort) begin
      clear   = 1'b1;
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            clear   = 1'b1;
            cnt_d   = CntW'(pCodingSize);
            state_d = ST_FILL;
          end
        end
        ST_FILL, ST_SKIP: begin
          if (i_src_valid) begin
            update = 1'b1;
            cnt_d  = cnt_q - 1'b1;
            if (cnt_q <= CntW'(1)) begin
              wcnt_d  = WcntW'(pResultLatency);
              state_d = ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          wcnt_d = wcnt_q - 1'b1;
          if (wcnt_q <= WcntW'(1)) begin
            state_d = ST_EMIT;
            if (is_match) begin
              flag_d    = 1'b1;
              offset_d  = i_match_offset[best_idx*pOffsetWidth +: pOffsetWidth];
              length_d  = best_len;
              literal_d = '0;
              last_d    = i_match_last[best_idx];
              skip_d    = CntW'(best_sym);
            end else begin
              flag_d    = 1'b0;
              offset_d  = '0;
              length_d  = '0;
              literal_d = i_lit_data;
              last_d    = i_lit_last;
              skip_d    = CntW'(1);
            end
          end
        end
        ST_EMIT: begin
          if (code.i_code_ready) begin
            if (last_q) begin
              state_d = ST_DONE;
            end else begin
              cnt_d   = skip_q;
              state_d = ST_SKIP;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      wcnt_q    <= '0;
      skip_q    <= '0;
      flag_q    <= 1'b0;
      offset_q  <= '0;
      length_q  <= '0;
      literal_q <= '0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wcnt_q    <= wcnt_d;
      skip_q    <= skip_d;
      flag_q    <= flag_d;
      offset_q  <= offset_d;
      length_q  <= length_d;
      literal_q <= literal_d;
      last_q    <= last_d;
    end
  end

  assign o_update            = update;
  assign o_clear             = clear;
  assign o_busy              = state_q inside {ST_FILL, ST_WAIT, ST_EMIT, ST_SKIP};
  assign o_done              = (state_q == ST_DONE);
  assign code.o_code_valid   = (state_q == ST_EMIT);
  assign code.o_code_flag    = flag_q;
  assign code.o_code_offset  = offset_q;
  assign code.o_code_length  = length_q;
  assign code.o_code_literal = literal_q;
  assign code.o_code_last    = last_q;

endmodule

// File: tb/tb_lzss_enc_sched.sv
// Bench for lzss_enc_sched: token-level model of selection and skip counts,
// checked every cycle, plus directed literal expectations.
module tb_lzss_enc_sched;

  localparam int NM = 32;

  logic clk = 1'b0;
  logic rst_x = 1'b0;
  logic start = 1'b0, abort = 1'b0, start3 = 1'b0, abort3 = 1'b0;
  logic src_valid = 1'b1;
  logic ready = 1'b1;
  int   src_mode = 1;  // 0: held high, 1: toggling, 2: held low

  logic [2:0] len_a  [NM];
  logic [5:0] off_a  [NM];
  logic       last_a [NM];
  logic [7:0] lit = '0;
  logic       lit_last = 1'b0;

  logic [NM*6-1:0] m_off;
  logic [NM*3-1:0] m_len;
  logic [NM-1:0]   m_last;

  logic upd0, clr0, busy0, done0, upd3, clr3, busy3, done3;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  always_comb begin
    m_off  = '0;
    m_len  = '0;
    m_last = '0;
    for (int i = 0; i < NM; i++) begin
      m_off[i*6 +: 6] = off_a[i];
      m_len[i*3 +: 3] = len_a[i];
      m_last[i]       = last_a[i];
    end
  end

  lzss_enc_sched_if #(.pDataWidth(8), .pOffsetWidth(6), .pLengthWidth(3)) code0 ();
  lzss_enc_sched_if #(.pDataWidth(8), .pOffsetWidth(6), .pLengthWidth(3)) code3 ();
  assign code0.i_code_ready = ready;
  assign code3.i_code_ready = ready;

  lzss_enc_sched dut (
    .clk(clk), .rst_x(rst_x), .i_start(start), .i_abort(abort), .i_src_valid(src_valid),
    .o_update(upd0), .o_clear(clr0), .i_match_offset(m_off), .i_match_length(m_len),
    .i_match_last(m_last), .i_lit_data(lit), .i_lit_last(lit_last), .code(code0),
    .o_busy(busy0), .o_done(done0)
  );

  lzss_enc_sched #(.pMinLength(3)) dut3 (
    .clk(clk), .rst_x(rst_x), .i_start(start3), .i_abort(abort3), .i_src_valid(src_valid),
    .o_update(upd3), .o_clear(clr3), .i_match_offset(m_off), .i_match_length(m_len),
    .i_match_last(m_last), .i_lit_data(lit), .i_lit_last(lit_last), .code(code3),
    .o_busy(busy3), .o_done(done3)
  );

  typedef struct {
    int flag;
    int off;
    int len;
    int lit;
    int last;
    int skip;
  } code_t;

  // Longest match wins, first unit on ties; below the minimum it is a literal.
  function automatic code_t model(int minlen);
    code_t c;
    int best = -1;
    int idx = 0;
    for (int i = 0; i < NM; i++)
      if (int'(len_a[i]) > best) begin
        best = int'(len_a[i]);
        idx  = i;
      end
    if (best + 1 >= minlen) begin
      c.flag = 1; c.off = int'(off_a[idx]); c.len = best; c.lit = 0;
      c.last = int'(last_a[idx]); c.skip = best + 1;
    end else begin
      c.flag = 0; c.off = 0; c.len = 0; c.lit = int'(lit);
      c.last = int'(lit_last); c.skip = 1;
    end
    return c;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  code_t held    [2];
  int    upd_cnt [2] = '{0, 0};
  int    exp_upd [2] = '{0, 0};
  bit    prev_v  [2] = '{1'b0, 1'b0};

  task automatic cmp(input int k, input int minlen, input logic upd, input logic clr,
                     input logic valid, input logic flag, input logic [5:0] off,
                     input logic [2:0] len, input logic [7:0] litv, input logic last);
    check("upd_clr_excl", 32'(upd & clr), 0);
    if (upd) check("upd_needs_src", 32'(src_valid), 1);
    if (valid) check("no_upd_in_emit", 32'(upd), 0);
    if (clr) begin
      upd_cnt[k] = 0;
      exp_upd[k] = 5;
    end
    if (upd) upd_cnt[k]++;
    if (valid && !prev_v[k]) begin
      held[k] = model(minlen);
      check("update_count", 32'(upd_cnt[k]), 32'(exp_upd[k]));
    end
    if (valid) begin
      check("code_flag", 32'(flag), 32'(held[k].flag));
      check("code_offset", 32'(off), 32'(held[k].off));
      check("code_length", 32'(len), 32'(held[k].len));
      check("code_literal", 32'(litv), 32'(held[k].lit));
      check("code_last", 32'(last), 32'(held[k].last));
      if (ready && !held[k].last) begin
        exp_upd[k] = held[k].skip;
        upd_cnt[k] = 0;
      end
    end
    prev_v[k] = valid;
  endtask

  always @(negedge clk) begin
    if (rst_x) begin
      cmp(0, 2, upd0, clr0, code0.o_code_valid, code0.o_code_flag, code0.o_code_offset,
          code0.o_code_length, code0.o_code_literal, code0.o_code_last);
      cmp(1, 3, upd3, clr3, code3.o_code_valid, code3.o_code_flag, code3.o_code_offset,
          code3.o_code_length, code3.o_code_literal, code3.o_code_last);
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (src_mode == 1) src_valid = ~src_valid;
    else src_valid = (src_mode == 0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic vld(input int k);
    return (k == 0) ? code0.o_code_valid : code3.o_code_valid;
  endfunction

  task automatic wait_valid(input int k);
    int n = 0;
    @(negedge clk);
    while (!vld(k) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("valid_timeout", 32'(vld(k)), 1);
  endtask

  task automatic clear_arrays();
    for (int i = 0; i < NM; i++) begin
      len_a[i]  = '0;
      off_a[i]  = 6'(i + 10);
      last_a[i] = 1'b0;
    end
  endtask

  code_t mc;

  initial begin
    clear_arrays();
    lit = 8'h41;
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(code0.o_code_valid), 0);
    check("rst_update", 32'(upd0), 0);
    check("rst_clear", 32'(clr0), 0);
    check("rst_busy", 32'(busy0), 0);
    check("rst_done", 32'(done0), 0);
    check("rst_offset", 32'(code0.o_code_offset), 0);
    check("rst_literal", 32'(code0.o_code_literal), 0);
    @(posedge clk); #1 rst_x = 1'b1;

    // Start, fill with toggling source, literal token
    @(posedge clk); #1 start = 1'b1;
    @(negedge clk);
    check("start_clear", 32'(clr0), 1);
    check("start_no_update", 32'(upd0), 0);
    @(posedge clk); #1 start = 1'b0;
    wait_valid(0);
    check("lit_flag", 32'(code0.o_code_flag), 0);
    check("lit_data", 32'(code0.o_code_literal), 32'h41);

    // Arbitration: unit3 L=2, unit7 L=4, unit9 L=4
    @(posedge clk); #1;
    len_a[3] = 3'd2; len_a[7] = 3'd4; len_a[9] = 3'd4;
    mc = model(2);
    check("model_arb_off", 32'(mc.off), 17);
    check("model_arb_len", 32'(mc.len), 4);
    check("model_arb_skip", 32'(mc.skip), 5);
    wait_valid(0);
    check("arb_flag", 32'(code0.o_code_flag), 1);
    check("arb_offset", 32'(code0.o_code_offset), 17);
    check("arb_length", 32'(code0.o_code_length), 4);

    // Backpressure on a final match code
    @(posedge clk); #1;
    ready = 1'b0;
    clear_arrays();
    len_a[5] = 3'd1; off_a[5] = 6'd33; last_a[5] = 1'b1;
    wait_valid(0);
    check("bp_last", 32'(code0.o_code_last), 1);
    check("bp_offset", 32'(code0.o_code_offset), 33);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < NM; i++) len_a[i] = 3'd7;
      lit = 8'hFF; lit_last = 1'b1;
    end
    ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("done_set", 32'(done0), 1);
    check("done_not_busy", 32'(busy0), 0);
    check("done_no_valid", 32'(code0.o_code_valid), 0);

    // Restart from DONE, then abort while stalled in SKIP
    @(posedge clk); #1;
    clear_arrays();
    lit = 8'h55; lit_last = 1'b0; ready = 1'b0; start = 1'b1;
    @(negedge clk);
    check("restart_clear", 32'(clr0), 1);
    @(posedge clk); #1 start = 1'b0;
    wait_valid(0);
    check("restart_lit", 32'(code0.o_code_literal), 32'h55);
    @(posedge clk); #1 src_mode = 2;
    repeat (2) @(posedge clk);
    #1 ready = 1'b1;
    @(posedge clk); #1 ready = 1'b0;
    @(negedge clk);
    check("skip_busy", 32'(busy0), 1);
    check("skip_stall", 32'(upd0), 0);
    @(posedge clk); #1 abort = 1'b1;
    @(negedge clk);
    check("abort_clear", 32'(clr0), 1);
    check("abort_no_update", 32'(upd0), 0);
    @(posedge clk); #1 abort = 1'b0; src_mode = 0; ready = 1'b1;
    @(negedge clk);
    check("abort_valid", 32'(code0.o_code_valid), 0);
    check("abort_busy", 32'(busy0), 0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("abort_idle_update", 32'(upd0), 0);
    end

    // Minimum length 3 on the second instance
    @(posedge clk); #1;
    clear_arrays();
    len_a[2] = 3'd1; lit = 8'h66; src_mode = 1; start3 = 1'b1;
    mc = model(3);
    check("model_min3_lit", 32'(mc.flag), 0);
    mc = model(2);
    check("model_min2_match", 32'(mc.flag), 1);
    @(posedge clk); #1 start3 = 1'b0;
    wait_valid(1);
    check("min3_lit_flag", 32'(code3.o_code_flag), 0);
    check("min3_lit_data", 32'(code3.o_code_literal), 32'h66);
    @(posedge clk); #1;
    len_a[4] = 3'd2; off_a[4] = 6'd9;
    wait_valid(1);
    check("min3_match_flag", 32'(code3.o_code_flag), 1);
    check("min3_match_off", 32'(code3.o_code_offset), 9);
    check("min3_match_len", 32'(code3.o_code_length), 2);
    wait_valid(1);
    @(posedge clk); #1 abort3 = 1'b1;
    @(posedge clk); #1 abort3 = 1'b0;
    @(negedge clk);
    check("abort3_busy", 32'(busy3), 0);

    // Asynchronous reset mid-stream
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_x = 1'b0;
    #1;
    check("async_rst_busy", 32'(busy0), 0);
    check("async_rst_update", 32'(upd0), 0);
    check("async_rst_valid", 32'(code0.o_code_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
